// File: rtl/ram_sdp_be_pkg.sv
// Constants shared by the memory blocks: clear-FSM state encodings and default geometry.
// init_done is high exactly when a RAM sits in RAM_ST_READY.
package ram_sdp_be_pkg;

    typedef enum logic {
        RAM_ST_CLEAR = 1'b0,
        RAM_ST_READY = 1'b1
    } ram_st_e;

    localparam int RAM_DEF_AW = 8;
    localparam int RAM_DEF_DW = 32;
    localparam int RAM_BYTE_W = 8;

endpackage

// File: rtl/ram_sdp_core.sv
// Unreset storage array with byte-strobe write and registered read-before-write; 1-cycle read latency.
// No backpressure: a write and a read are accepted every cycle.
module ram_sdp_core
    import ram_sdp_be_pkg::*;
#(
    parameter int AW = RAM_DEF_AW,
    parameter int DW = RAM_DEF_DW
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [AW-1:0]            waddr_i,
    input  logic [DW-1:0]            wdat_i,
    input  logic [DW/RAM_BYTE_W-1:0] wstrb_i,
    input  logic                     re_i,
    input  logic [AW-1:0]            raddr_i,
    output logic [DW-1:0]            rdat_o
);

    localparam int NB = DW / RAM_BYTE_W;

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdat_q;

    // The read samples the array before this edge's write lands (old data on collision).
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][i*RAM_BYTE_W +: RAM_BYTE_W] <= wdat_i[i*RAM_BYTE_W +: RAM_BYTE_W];
                end
            end
        end
        if (re_i) begin
            rdat_q <= mem_q[raddr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port byte-strobe RAM with post-reset clear sweep, optional RDW bypass and output register.
// Read latency OUT_REG+1 cycles; no backpressure, ports are ignored until init_done.
module ram_sdp_be
    import ram_sdp_be_pkg::*;
#(
    parameter int AW           = RAM_DEF_AW,
    parameter int DW           = RAM_DEF_DW,
    parameter int BYPASS       = 1,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            init_done,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rd,
    output logic            rvalid,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wr,
    input  logic [DW/8-1:0] wstrb
);

    localparam int NB = DW / RAM_BYTE_W;

    generate
        if ((DW % RAM_BYTE_W) != 0 || DW == 0) begin : g_dw_chk
            $error("ram_sdp_be: DW must be a non-zero multiple of 8");
        end
    endgenerate

    ram_st_e       state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RAM_ST_CLEAR) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == {AW{1'b1}}) begin
                state_d = RAM_ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= (CLEAR_ON_RST != 0) ? RAM_ST_CLEAR : RAM_ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_done = (state_q == RAM_ST_READY);

    // Gating with rst keeps the array untouched while reset is held.
    logic sweeping, user_en, acc_re, acc_we;
    assign sweeping = rst && (state_q == RAM_ST_CLEAR);
    assign user_en  = rst && (state_q == RAM_ST_READY);
    assign acc_re   = user_en && re;
    assign acc_we   = user_en && we;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdat;
    logic [NB-1:0]   mem_wstrb;
    logic [DW-1:0]   core_rdat;

    assign mem_we    = sweeping || acc_we;
    assign mem_waddr = sweeping ? cnt_q : waddr;
    assign mem_wdat  = sweeping ? '0 : wr;
    assign mem_wstrb = sweeping ? '1 : wstrb;

    ram_sdp_core #(
        .AW (AW),
        .DW (DW)
    ) u_core (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdat_i  (mem_wdat),
        .wstrb_i (mem_wstrb),
        .re_i    (acc_re),
        .raddr_i (raddr),
        .rdat_o  (core_rdat)
    );

    // Colliding write is captured so its strobed bytes can overlay the old read data.
    logic          v1_q;
    logic          byp_d, byp_q;
    logic [DW-1:0] byp_dat_q;
    logic [NB-1:0] byp_strb_q;
    logic [DW-1:0] merged;

    assign byp_d = (BYPASS != 0) && acc_re && acc_we && (raddr == waddr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q       <= 1'b0;
            byp_q      <= 1'b0;
            byp_dat_q  <= '0;
            byp_strb_q <= '0;
        end else begin
            v1_q  <= acc_re;
            byp_q <= byp_d;
            if (byp_d) begin
                byp_dat_q  <= wr;
                byp_strb_q <= wstrb;
            end
        end
    end

    always_comb begin
        merged = core_rdat;
        for (int i = 0; i < NB; i++) begin
            if (byp_q && byp_strb_q[i]) begin
                merged[i*RAM_BYTE_W +: RAM_BYTE_W] = byp_dat_q[i*RAM_BYTE_W +: RAM_BYTE_W];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          v2_q;
            logic [DW-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    v2_q <= 1'b0;
                    rd_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        rd_q <= merged;
                    end
                end
            end

            assign rd     = rd_q;
            assign rvalid = v2_q;
        end else begin : g_out_direct
            // The core register is unreset and unmerged, so a separate copy holds rd between reads.
            logic [DW-1:0] hold_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    hold_q <= '0;
                end else if (v1_q) begin
                    hold_q <= merged;
                end
            end

            assign rd     = v1_q ? merged : hold_q;
            assign rvalid = v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: defaults, BYPASS=0, and OUT_REG=1/AW=4/DW=64 instances against a behavioural model.
module tb_ram_sdp_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_re, a_we;
    logic [7:0]  a_raddr, a_waddr;
    logic [31:0] a_wr;
    logic [3:0]  a_wstrb;

    logic        b_re, b_we;
    logic [3:0]  b_raddr, b_waddr;
    logic [63:0] b_wr;
    logic [7:0]  b_wstrb;

    logic        d0_init, d0_rvalid, d1_init, d1_rvalid, d2_init, d2_rvalid;
    logic [31:0] d0_rd, d1_rd;
    logic [63:0] d2_rd;

    ram_sdp_be #(.AW(8), .DW(32), .BYPASS(1), .OUT_REG(0), .CLEAR_ON_RST(1)) u_d0 (
        .clk(clk), .rst(rst), .init_done(d0_init), .re(a_re), .raddr(a_raddr), .rd(d0_rd),
        .rvalid(d0_rvalid), .we(a_we), .waddr(a_waddr), .wr(a_wr), .wstrb(a_wstrb));

    ram_sdp_be #(.AW(8), .DW(32), .BYPASS(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u_d1 (
        .clk(clk), .rst(rst), .init_done(d1_init), .re(a_re), .raddr(a_raddr), .rd(d1_rd),
        .rvalid(d1_rvalid), .we(a_we), .waddr(a_waddr), .wr(a_wr), .wstrb(a_wstrb));

    ram_sdp_be #(.AW(4), .DW(64), .BYPASS(1), .OUT_REG(1), .CLEAR_ON_RST(1)) u_d2 (
        .clk(clk), .rst(rst), .init_done(d2_init), .re(b_re), .raddr(b_raddr), .rd(d2_rd),
        .rvalid(d2_rvalid), .we(b_we), .waddr(b_waddr), .wr(b_wr), .wstrb(b_wstrb));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] strb);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Behavioural model: memory contents, cycles since reset release, expected outputs.
    logic [31:0] ma [256];
    logic [63:0] mb [16];
    int          cyc;
    logic        ea_v, eb_p1v, eb_v;
    logic [31:0] ea_d0, ea_d1;
    logic [63:0] eb_p1d, eb_d, t_old, t_new;

    always @(posedge clk) begin
        if (!rst) begin
            cyc = 0;
            ea_v = 1'b0; ea_d0 = '0; ea_d1 = '0;
            eb_p1v = 1'b0; eb_v = 1'b0; eb_p1d = '0; eb_d = '0;
        end else begin
            if (cyc >= 256 && a_re) begin
                t_old = 64'(ma[a_raddr]);
                t_new = t_old;
                if (a_we && a_waddr == a_raddr) t_new = merge(t_old, 64'(a_wr), 8'(a_wstrb));
                ea_v = 1'b1; ea_d0 = t_new[31:0]; ea_d1 = t_old[31:0];
            end else begin
                ea_v = 1'b0;
            end
            if (cyc >= 256 && a_we) begin
                t_new = merge(64'(ma[a_waddr]), 64'(a_wr), 8'(a_wstrb));
                ma[a_waddr] = t_new[31:0];
            end

            if (eb_p1v) eb_d = eb_p1d;
            eb_v = eb_p1v;
            if (cyc >= 16 && b_re) begin
                t_old = mb[b_raddr];
                t_new = t_old;
                if (b_we && b_waddr == b_raddr) t_new = merge(t_old, b_wr, b_wstrb);
                eb_p1v = 1'b1; eb_p1d = t_new;
            end else begin
                eb_p1v = 1'b0;
            end
            if (cyc >= 16 && b_we) mb[b_waddr] = merge(mb[b_waddr], b_wr, b_wstrb);

            cyc++;
            if (cyc == 256) for (int i = 0; i < 256; i++) ma[i] = '0;
            if (cyc == 16)  for (int i = 0; i < 16; i++)  mb[i] = '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("d0_init",   64'(d0_init),   64'(cyc >= 256));
            chk("d0_rvalid", 64'(d0_rvalid), 64'(ea_v));
            chk("d0_rd",     64'(d0_rd),     64'(ea_d0));
            chk("d1_init",   64'(d1_init),   64'(cyc >= 256));
            chk("d1_rvalid", 64'(d1_rvalid), 64'(ea_v));
            chk("d1_rd",     64'(d1_rd),     64'(ea_d1));
            chk("d2_init",   64'(d2_init),   64'(cyc >= 16));
            chk("d2_rvalid", 64'(d2_rvalid), 64'(eb_v));
            chk("d2_rd",     d2_rd,          eb_d);
        end
    end

    task automatic a_idle();
        a_re = 1'b0; a_we = 1'b0; a_raddr = '0; a_waddr = '0; a_wr = '0; a_wstrb = '0;
    endtask

    // Writes and reads aimed at address 0x05 while the sweep runs must vanish.
    task automatic clear_noise(input int c);
        if (c >= 10 && c < 20) begin
            a_we = 1'b1; a_waddr = 8'h05; a_wr = 32'hFFFF_FFFF; a_wstrb = 4'hF;
            a_re = 1'b1; a_raddr = 8'h05;
        end else begin
            a_idle();
        end
    endtask

    task automatic a_wrt(input logic [7:0] addr, input logic [31:0] dat, input logic [3:0] strb);
        a_we = 1'b1; a_waddr = addr; a_wr = dat; a_wstrb = strb;
        @(negedge clk);
        a_we = 1'b0;
    endtask

    task automatic a_rd(input logic [7:0] addr, input logic [31:0] e0, input logic [31:0] e1,
                        input string nm);
        a_re = 1'b1; a_raddr = addr;
        @(negedge clk);
        a_re = 1'b0;
        chk({nm, "_rvalid"}, 64'(d0_rvalid), 64'(1));
        chk({nm, "_byp1"},   64'(d0_rd),     64'(e0));
        chk({nm, "_byp0"},   64'(d1_rd),     64'(e1));
    endtask

    initial begin
        int          cnt;
        bit          done;
        logic [63:0] pat;

        rst = 1'b0;
        a_idle();
        b_re = 1'b0; b_we = 1'b0; b_raddr = '0; b_waddr = '0; b_wr = '0; b_wstrb = '0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rd",     64'(d0_rd),     64'(0));
        chk("rst_rvalid", 64'(d0_rvalid), 64'(0));
        chk("rst_init",   64'(d0_init),   64'(0));

        // First sweep, interrupted by reset at cycle 100.
        rst = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            clear_noise(c);
            @(negedge clk);
            if (c == 15) chk("clr_rvalid", 64'(d0_rvalid), 64'(0));
        end
        chk("mid_init", 64'(d0_init), 64'(0));
        rst = 1'b0;
        a_idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        cnt = 0;
        done = 1'b0;
        while (!done && cnt < 400) begin
            clear_noise(cnt + 1);
            @(negedge clk);
            cnt++;
            if (cnt == 15) chk("d2_init_15", 64'(d2_init), 64'(0));
            if (cnt == 16) chk("d2_init_16", 64'(d2_init), 64'(1));
            if (d0_init) done = 1'b1;
        end
        a_idle();
        chk("sweep_len", 64'(cnt), 64'(256));

        a_rd(8'h00, 32'h0, 32'h0, "clr_00");
        a_rd(8'h7F, 32'h0, 32'h0, "clr_7f");
        a_rd(8'hFF, 32'h0, 32'h0, "clr_ff");
        a_rd(8'h05, 32'h0, 32'h0, "ign_05");

        a_wrt(8'h10, 32'hAABB_CCDD, 4'hF);
        a_wrt(8'h10, 32'h1122_3344, 4'b0101);
        a_rd(8'h10, 32'hAA22_CC44, 32'hAA22_CC44, "strb");
        a_wrt(8'h10, 32'hFFFF_FFFF, 4'h0);
        a_rd(8'h10, 32'hAA22_CC44, 32'hAA22_CC44, "strb0");

        a_we = 1'b1; a_waddr = 8'h20; a_wr = 32'hDEAD_BEEF; a_wstrb = 4'b0011;
        a_re = 1'b1; a_raddr = 8'h20;
        @(negedge clk);
        a_idle();
        chk("rdw_byp1", 64'(d0_rd), 64'(32'h0000_BEEF));
        chk("rdw_byp0", 64'(d1_rd), 64'(32'h0000_0000));
        a_rd(8'h20, 32'h0000_BEEF, 32'h0000_BEEF, "rdw_next");

        a_wrt(8'hFF, 32'h1234_5678, 4'hF);
        a_rd(8'h00, 32'h0, 32'h0, "wrap_00");
        a_rd(8'hFF, 32'h1234_5678, 32'h1234_5678, "wrap_ff");

        // OUT_REG=1 instance: pre-fill, then 16 back-to-back reads.
        pat = 64'h0101_0101_0101_0101;
        for (int i = 0; i < 16; i++) begin
            b_we = 1'b1; b_waddr = 4'(i); b_wr = pat * 64'(i); b_wstrb = 8'hFF;
            @(negedge clk);
        end
        b_we = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            b_re = (i < 16); b_raddr = 4'(i);
            @(negedge clk);
            if (i >= 1 && i <= 16) begin
                chk("or_rvalid", 64'(d2_rvalid), 64'(1));
                chk("or_rd",     d2_rd,          pat * 64'(i - 1));
            end else begin
                chk("or_rvalid_idle", 64'(d2_rvalid), 64'(0));
            end
        end
        b_re = 1'b0;

        // Randomised traffic; narrow address range half the time to force collisions.
        for (int n = 0; n < 1500; n++) begin
            a_re    = 1'($urandom_range(0, 1));
            a_we    = 1'($urandom_range(0, 1));
            a_raddr = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            a_waddr = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            a_wr    = $urandom;
            a_wstrb = 4'($urandom_range(0, 15));
            b_re    = 1'($urandom_range(0, 1));
            b_we    = 1'($urandom_range(0, 1));
            b_raddr = 4'($urandom_range(0, 15));
            b_waddr = $urandom_range(0, 1) ? b_raddr : 4'($urandom_range(0, 15));
            b_wr    = {$urandom, $urandom};
            b_wstrb = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        a_idle();
        b_re = 1'b0; b_we = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
